// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Multi-channel LED pattern generator driving the board LED bank.
//            A free-running prescaler sets the pattern step period; a
//            one-cycle strobe loads a new mode and restarts its pattern.
//            Modes: 0 OFF, 1 ON, 2 BLINK, 3 CHASE, 4 BOUNCE, 5 BREATHE,
//            6/7 reserved (behave as OFF).
// Ports    : clk        system clock
//            rst        synchronous reset, active-high
//            mode_in    requested mode, sampled when mode_load=1
//            mode_load  single-cycle strobe: load mode_in, restart pattern
//            leds       registered LED drive, bit0 = first LED
//            tick       high while the prescaler is all-ones
//            mode_q     currently active mode
// Revision : 1.0  initial release
// ============================================================================
module led_pattern_gen #(
    parameter int NUM_LEDS   = 8,
    parameter int PRESCALE_W = 22,
    parameter int PWM_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          mode_in,
    input  logic                mode_load,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick,
    output logic [2:0]          mode_q
);

    localparam logic [2:0] c_MODE_OFF     = 3'd0;
    localparam logic [2:0] c_MODE_ON      = 3'd1;
    localparam logic [2:0] c_MODE_BLINK   = 3'd2;
    localparam logic [2:0] c_MODE_CHASE   = 3'd3;
    localparam logic [2:0] c_MODE_BOUNCE  = 3'd4;
    localparam logic [2:0] c_MODE_BREATHE = 3'd5;

    localparam logic [NUM_LEDS-1:0]   c_POS_FIRST = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0]   c_POS_LAST  = c_POS_FIRST << (NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0]   c_LEDS_ALL  = '1;
    localparam logic [PWM_W-1:0]      c_DUTY_MAX  = '1;
    localparam logic [PRESCALE_W-1:0] c_PRE_MAX   = '1;

    // Registered state
    logic [PRESCALE_W-1:0] r_prescaler;
    logic [PWM_W-1:0]      r_pwm_cnt;
    logic [2:0]            r_mode;
    logic [NUM_LEDS-1:0]   r_leds;
    logic [NUM_LEDS-1:0]   r_pos;
    logic                  r_dir;       // 1 = up (towards MSB / increasing duty)
    logic                  r_phase;
    logic [PWM_W-1:0]      r_duty;

    // Next-state values
    logic [PRESCALE_W-1:0] w_prescaler_nxt;
    logic [PWM_W-1:0]      w_pwm_cnt_nxt;
    logic [2:0]            w_mode_nxt;
    logic [NUM_LEDS-1:0]   w_leds_nxt;
    logic [NUM_LEDS-1:0]   w_pos_nxt;
    logic                  w_dir_nxt;
    logic                  w_phase_nxt;
    logic [PWM_W-1:0]      w_duty_nxt;

    logic                  w_tick;
    logic                  w_step;
    logic [NUM_LEDS-1:0]   w_rot_left;
    logic [NUM_LEDS-1:0]   w_shl;
    logic [NUM_LEDS-1:0]   w_shr;

    assign w_tick = (r_prescaler == c_PRE_MAX);
    // A load on a tick cycle takes priority and suppresses the step.
    assign w_step = w_tick & ~mode_load;

    // A single LED has nowhere to move: all position updates hold it.
    generate
        if (NUM_LEDS > 1) begin : g_multi
            assign w_rot_left = {r_pos[NUM_LEDS-2:0], r_pos[NUM_LEDS-1]};
            assign w_shl      = r_pos << 1;
            assign w_shr      = r_pos >> 1;
        end else begin : g_single
            assign w_rot_left = r_pos;
            assign w_shl      = r_pos;
            assign w_shr      = r_pos;
        end
    endgenerate

    always_comb begin
        w_prescaler_nxt = r_prescaler + 1'b1;
        w_pwm_cnt_nxt   = r_pwm_cnt + 1'b1;
        w_mode_nxt      = r_mode;
        w_leds_nxt      = r_leds;
        w_pos_nxt       = r_pos;
        w_dir_nxt       = r_dir;
        w_phase_nxt     = r_phase;
        w_duty_nxt      = r_duty;

        if (mode_load) begin
            w_prescaler_nxt = '0;
            w_pwm_cnt_nxt   = '0;
            w_mode_nxt      = mode_in;
            w_pos_nxt       = c_POS_FIRST;
            w_dir_nxt       = 1'b1;
            w_phase_nxt     = 1'b0;
            w_duty_nxt      = '0;
            case (mode_in)
                c_MODE_ON:     w_leds_nxt = c_LEDS_ALL;
                c_MODE_BLINK: begin
                    // Blink starts lit, so the phase must read 1 to match.
                    w_leds_nxt  = c_LEDS_ALL;
                    w_phase_nxt = 1'b1;
                end
                c_MODE_CHASE:  w_leds_nxt = c_POS_FIRST;
                c_MODE_BOUNCE: w_leds_nxt = c_POS_FIRST;
                default:       w_leds_nxt = '0;
            endcase
        end else begin
            case (r_mode)
                c_MODE_OFF:   w_leds_nxt = '0;
                c_MODE_ON:    w_leds_nxt = c_LEDS_ALL;
                c_MODE_BLINK: begin
                    if (w_step) begin
                        w_phase_nxt = ~r_phase;
                        w_leds_nxt  = {NUM_LEDS{~r_phase}};
                    end
                end
                c_MODE_CHASE: begin
                    if (w_step) begin
                        w_pos_nxt  = w_rot_left;
                        w_leds_nxt = w_rot_left;
                    end
                end
                c_MODE_BOUNCE: begin
                    if (w_step) begin
                        // Direction flips on the step that reaches an end, so
                        // each end position is shown for exactly one step.
                        if (r_dir) begin
                            w_pos_nxt = w_shl;
                            if (w_shl == c_POS_LAST) w_dir_nxt = 1'b0;
                        end else begin
                            w_pos_nxt = w_shr;
                            if (w_shr == c_POS_FIRST) w_dir_nxt = 1'b1;
                        end
                        w_leds_nxt = w_pos_nxt;
                    end
                end
                c_MODE_BREATHE: begin
                    // PWM compare is re-registered every clock.
                    w_leds_nxt = {NUM_LEDS{r_pwm_cnt < r_duty}};
                    if (w_step) begin
                        // Same end-of-travel flip as BOUNCE; the guarded
                        // branches keep duty from ever wrapping.
                        if (r_dir) begin
                            if (r_duty == c_DUTY_MAX) begin
                                w_dir_nxt  = 1'b0;
                                w_duty_nxt = r_duty - 1'b1;
                            end else begin
                                w_duty_nxt = r_duty + 1'b1;
                                if (w_duty_nxt == c_DUTY_MAX) w_dir_nxt = 1'b0;
                            end
                        end else begin
                            if (r_duty == '0) begin
                                w_dir_nxt  = 1'b1;
                                w_duty_nxt = r_duty + 1'b1;
                            end else begin
                                w_duty_nxt = r_duty - 1'b1;
                                if (w_duty_nxt == '0) w_dir_nxt = 1'b1;
                            end
                        end
                    end
                end
                default:      w_leds_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
            r_mode      <= c_MODE_OFF;
            r_leds      <= '0;
            r_pos       <= c_POS_FIRST;
            r_dir       <= 1'b1;
            r_phase     <= 1'b0;
            r_duty      <= '0;
        end else begin
            r_prescaler <= w_prescaler_nxt;
            r_pwm_cnt   <= w_pwm_cnt_nxt;
            r_mode      <= w_mode_nxt;
            r_leds      <= w_leds_nxt;
            r_pos       <= w_pos_nxt;
            r_dir       <= w_dir_nxt;
            r_phase     <= w_phase_nxt;
            r_duty      <= w_duty_nxt;
        end
    end

    assign leds   = r_leds;
    assign tick   = w_tick;
    assign mode_q = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Purpose  : Self-checking bench for led_pattern_gen. Two instances (4 LEDs
//            and 1 LED) share stimulus; expected outputs come from a model
//            that derives each pattern from the cycle count since the last
//            reset/load and are queued for a negedge monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int PW = 4;
    localparam int MW = 3;
    localparam int N  = 4;
    localparam int STEP_CYC = 1 << PW;
    localparam int PWM_CYC  = 1 << MW;
    localparam int DUTY_MAX = (1 << MW) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode_load = 1'b0;
    logic [2:0]   mode_in = 3'd0;

    logic [N-1:0] leds_a;
    logic         tick_a;
    logic [2:0]   mode_a;
    logic [0:0]   leds_b;
    logic         tick_b;
    logic [2:0]   mode_b;

    led_pattern_gen #(.NUM_LEDS(N), .PRESCALE_W(PW), .PWM_W(MW)) u_dut_a (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_load(mode_load),
        .leds(leds_a), .tick(tick_a), .mode_q(mode_a));

    led_pattern_gen #(.NUM_LEDS(1), .PRESCALE_W(PW), .PWM_W(MW)) u_dut_b (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_load(mode_load),
        .leds(leds_b), .tick(tick_b), .mode_q(mode_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] leds_a;
        logic         leds_b;
        logic         tick;
        logic [2:0]   mode;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Model state: active mode and clock edges since the last reset/load.
    int  m_mode  = 0;
    int  m_cyc   = 0;
    bit  m_valid = 1'b0;
    bit  done    = 1'b0;

    // Expected LED word for an n-LED instance, from mode and elapsed cycles.
    function automatic logic [N-1:0] f_leds(int n, int md, int c);
        int k, p, i, d, cp;
        logic [N-1:0] ones;
        ones = N'((1 << n) - 1);
        k = c / STEP_CYC;
        case (md)
            1: return ones;
            2: return (k % 2 == 0) ? ones : '0;
            3: return N'(1 << (k % n));
            4: begin
                if (n == 1) return N'(1);
                p = 2 * (n - 1);
                i = k % p;
                return N'(1 << ((i < n) ? i : p - i));
            end
            5: begin
                if (c == 0) return '0;
                cp = c - 1;
                i  = (cp / STEP_CYC) % (2 * DUTY_MAX);
                d  = (i <= DUTY_MAX) ? i : 2 * DUTY_MAX - i;
                return ((cp % PWM_CYC) < d) ? ones : '0;
            end
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock edge, update the model from the inputs seen at that
    // edge and queue the expected outputs for the monitor.
    task automatic edge_step();
        exp_t e;
        logic [N-1:0] tmp;
        @(posedge clk);
        #1;
        if (rst) begin
            m_mode  = 0;
            m_cyc   = 0;
            m_valid = 1'b1;
        end else if (mode_load) begin
            m_mode = int'(mode_in);
            m_cyc  = 0;
        end else begin
            m_cyc++;
        end
        if (m_valid) begin
            e.leds_a = f_leds(N, m_mode, m_cyc);
            tmp      = f_leds(1, m_mode, m_cyc);
            e.leds_b = tmp[0];
            e.tick   = ((m_cyc % STEP_CYC) == STEP_CYC - 1);
            e.mode   = 3'(m_mode);
            q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        rst       = 1'b0;
        mode_load = 1'b0;
        repeat (n) edge_step();
    endtask

    task automatic load(input int m);
        rst       = 1'b0;
        mode_in   = 3'(m);
        mode_load = 1'b1;
        edge_step();
        mode_load = 1'b0;
    endtask

    // Run until the current cycle is a tick cycle, so the next edge lands on it.
    task automatic wait_tick_cycle();
        while ((m_cyc % STEP_CYC) != STEP_CYC - 1) edge_step();
    endtask

    // Monitor: compare each queued expectation away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("leds_n4", int'(leds_a), int'(e.leds_a));
                chk("leds_n1", int'(leds_b), int'(e.leds_b));
                chk("tick_n4", int'(tick_a), int'(e.tick));
                chk("tick_n1", int'(tick_b), int'(e.tick));
                chk("mode_n4", int'(mode_a), int'(e.mode));
                chk("mode_n1", int'(mode_b), int'(e.mode));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset held three cycles, then idle in OFF.
        rst = 1'b1;
        repeat (3) edge_step();
        run(40);
        // CHASE through a full wrap.
        load(3);
        run(5 * STEP_CYC);
        // BOUNCE for more than one full sweep.
        load(4);
        run(9 * STEP_CYC);
        // BLINK, then a load landing exactly on a tick cycle.
        load(2);
        run(2 * STEP_CYC);
        wait_tick_cycle();
        load(3);
        run(2 * STEP_CYC);
        // BREATHE across a full rise and fall and into the next rise.
        load(5);
        run(32 * STEP_CYC);
        // Reset mid-CHASE at the third position, then a reserved mode.
        load(3);
        run(2 * STEP_CYC);
        rst = 1'b1;
        edge_step();
        load(6);
        run(20);
        // Same-mode reload restarts the pattern.
        load(3);
        run(STEP_CYC + 3);
        load(3);
        run(STEP_CYC + 2);
        // Randomized mode loads, tick-aligned loads and reset pulses.
        repeat (60) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rst = 1'b1;
                edge_step();
                run(int'($urandom_range(1, 20)));
            end else if (r <= 3) begin
                wait_tick_cycle();
                load(int'($urandom_range(0, 7)));
                run(int'($urandom_range(1, 60)));
            end else begin
                load(int'($urandom_range(0, 7)));
                run(int'($urandom_range(1, 90)));
            end
        end
        run(4);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            chk("queue_drain", q.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
